// File: rtl/rv32i_apb_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_apb_pkg
// Shared definitions for the RV32I data-port to APB bridge:
//   - bridge FSM state encoding
//   - core access-size encodings carried on store_size
//   - default peripheral window base and the timeout read-data marker
// ---------------------------------------------------------------------------
package rv32i_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // 64 KiB peripheral window; only bits [31:16] take part in the decode.
  localparam logic [31:0] PERIPH_BASE_DEF = 32'h1000_0000;

  // Returned on dRdata when a slave never raises PREADY.
  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/rv32i_apb_bridge_if.sv
// ---------------------------------------------------------------------------
// rv32i_apb_bridge_if
// APB bus bundle between the bridge and its peripherals.
//   PADDR   32          byte address, word aligned
//   PSEL    NUM_SLAVES  one-hot slave select
//   PENABLE 1           access phase
//   PWRITE  1           1 = write
//   PWDATA  32          lane-replicated write data
//   PSTRB   4           byte strobes (zero for reads)
//   PRDATA  32          read data from the selected slave
//   PREADY  1           slave completion
//   PSLVERR 1           slave error, valid with PREADY
// Modports: master = bridge side, slave = peripheral side.
// ---------------------------------------------------------------------------
interface rv32i_apb_bridge_if #(
  parameter int NUM_SLAVES = 4
) ();

  logic [31:0]           PADDR;
  logic [NUM_SLAVES-1:0] PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic [3:0]            PSTRB;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_lane_align.sv
// ---------------------------------------------------------------------------
// apb_lane_align
// Combinational lane steering for core stores onto the 32-bit APB bus.
//   size     in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD)
//   addr_lo  in  2   byte offset within the word
//   wr_en    in  1   1 = store; loads get an all-zero strobe
//   data     in  32  right-aligned store data
//   strb     out 4   byte strobes
//   wdata    out 32  byte/half replicated across all lanes, word unchanged
//   misalign out 1   unusable size/offset combination (includes SZ_RSVD)
// ---------------------------------------------------------------------------
module apb_lane_align
  import rv32i_apb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        wr_en,
  input  logic [31:0] data,
  output logic [3:0]  strb,
  output logic [31:0] wdata,
  output logic        misalign
);

  always_comb begin
    strb     = 4'b0000;
    wdata    = data;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
        if (wr_en) strb = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        wdata    = {2{data[15:0]}};
        misalign = addr_lo[0];
        if (wr_en) strb = 4'b0011 << addr_lo;
      end
      SZ_WORD: begin
        misalign = (addr_lo != 2'b00);
        if (wr_en) strb = 4'b1111;
      end
      default: begin
        // Reserved size code is rejected the same way as a misaligned access.
        misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rv32i_apb_bridge.sv
// ---------------------------------------------------------------------------
// rv32i_apb_bridge
// Converts single core data-port transfers in the peripheral window into
// APB SETUP/ACCESS transactions. One transfer in flight; req is only looked
// at in IDLE (which includes the cycle carrying the ready pulse), so the
// fastest back-to-back rate is one transfer every three cycles.
//   clk         in  1   rising-edge clock
//   rst         in  1   asynchronous active-low reset
//   req         in  1   transfer request
//   d_wr_en     in  1   1 = store, 0 = load
//   dAddr       in  32  byte address
//   dWdata      in  32  right-aligned store data
//   store_size  in  2   00 byte, 01 half, 10 word
//   dRdata      out 32  load data (0 on decode error, DEADBEEF on timeout)
//   ready       out 1   one-cycle completion pulse
//   err         out 1   error flag, only ever high together with ready
//   apb         master  APB bus (see rv32i_apb_bridge_if)
// ---------------------------------------------------------------------------
module rv32i_apb_bridge
  import rv32i_apb_pkg::*;
#(
  parameter int          NUM_SLAVES  = 4,
  parameter int          TIMEOUT     = 16,
  parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        d_wr_en,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  input  logic [1:0]  store_size,
  output logic [31:0] dRdata,
  output logic        ready,
  output logic        err,
  rv32i_apb_bridge_if.master apb
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_t            state;
  logic [CNT_W-1:0]      tmo_cnt;

  logic [3:0]            slv_idx;
  logic                  in_window;
  logic                  slv_ok;
  logic                  dec_err;
  logic [NUM_SLAVES-1:0] sel_onehot;
  logic [3:0]            lane_strb;
  logic [31:0]           lane_wdata;
  logic                  lane_misalign;

  apb_lane_align u_lane_align (
    .size     (store_size),
    .addr_lo  (dAddr[1:0]),
    .wr_en    (d_wr_en),
    .data     (dWdata),
    .strb     (lane_strb),
    .wdata    (lane_wdata),
    .misalign (lane_misalign)
  );

  // Request decode, evaluated straight off the core inputs while IDLE.
  assign slv_idx    = dAddr[15:12];
  assign in_window  = (dAddr[31:16] == PERIPH_BASE[31:16]);
  assign slv_ok     = (int'(slv_idx) < NUM_SLAVES);
  assign dec_err    = !in_window || !slv_ok || lane_misalign;
  assign sel_onehot = NUM_SLAVES'(1) << slv_idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      apb.PSEL    <= '0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      apb.PSTRB   <= '0;
      dRdata      <= '0;
      ready       <= 1'b0;
      err         <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        // IDLE: accept a request; the APB address/data registers double as
        // the latched copy of the core request for the rest of the transfer.
        ST_IDLE: begin
          if (req) begin
            if (dec_err) begin
              ready  <= 1'b1;
              err    <= 1'b1;
              dRdata <= '0;
            end else begin
              state      <= ST_SETUP;
              tmo_cnt    <= '0;
              apb.PSEL   <= sel_onehot;
              apb.PADDR  <= {dAddr[31:2], 2'b00};
              apb.PWRITE <= d_wr_en;
              apb.PWDATA <= lane_wdata;
              apb.PSTRB  <= lane_strb;
            end
          end
        end

        // SETUP: exactly one cycle with PSEL up and PENABLE low.
        ST_SETUP: begin
          state       <= ST_ACCESS;
          apb.PENABLE <= 1'b1;
        end

        // ACCESS: hold everything until PREADY or the wait budget runs out.
        ST_ACCESS: begin
          if (apb.PREADY) begin
            if (!apb.PWRITE) dRdata <= apb.PRDATA;
            ready       <= 1'b1;
            err         <= apb.PSLVERR;
            apb.PSEL    <= '0;
            apb.PENABLE <= 1'b0;
            state       <= ST_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            ready       <= 1'b1;
            err         <= 1'b1;
            dRdata      <= DEADBEEF;
            apb.PSEL    <= '0;
            apb.PENABLE <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          apb.PSEL    <= '0;
          apb.PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_rv32i_apb_bridge
// Directed bench for rv32i_apb_bridge. Inputs are driven and outputs are
// sampled on the falling clock edge; the APB slave is played by hand.
// ---------------------------------------------------------------------------
module tb_rv32i_apb_bridge;
  import rv32i_apb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        d_wr_en;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [1:0]  store_size;
  logic [31:0] dRdata;
  logic        ready;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  rv32i_apb_bridge_if #(.NUM_SLAVES(4)) apb ();

  rv32i_apb_bridge #(
    .NUM_SLAVES  (4),
    .TIMEOUT     (16),
    .PERIPH_BASE (32'h1000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .d_wr_en    (d_wr_en),
    .dAddr      (dAddr),
    .dWdata     (dWdata),
    .store_size (store_size),
    .dRdata     (dRdata),
    .ready      (ready),
    .err        (err),
    .apb        (apb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz);
    req        = 1'b1;
    d_wr_en    = wr;
    dAddr      = a;
    dWdata     = d;
    store_size = sz;
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; d_wr_en = 1'b0; dAddr = '0; dWdata = '0; store_size = '0;
    apb.PREADY = 1'b0; apb.PRDATA = '0; apb.PSLVERR = 1'b0;
    tick(); tick();
    chk("rst_psel",    32'(apb.PSEL),    32'h0);
    chk("rst_penable", 32'(apb.PENABLE), 32'h0);
    chk("rst_paddr",   apb.PADDR,        32'h0);
    chk("rst_ready",   32'(ready),       32'h0);
    chk("rst_drdata",  dRdata,           32'h0);
    rst = 1'b1;
    tick();

    // Word store, slave ready immediately; inputs wiggle while busy.
    drive(1'b1, 32'h1000_1004, 32'h1234_5678, SZ_WORD);
    apb.PREADY = 1'b1;
    tick();
    chk("t1_psel",          32'(apb.PSEL),    32'h2);
    chk("t1_penable_setup", 32'(apb.PENABLE), 32'h0);
    chk("t1_paddr",         apb.PADDR,        32'h1000_1004);
    chk("t1_pstrb",         32'(apb.PSTRB),   32'hF);
    chk("t1_pwdata",        apb.PWDATA,       32'h1234_5678);
    chk("t1_pwrite",        32'(apb.PWRITE),  32'h1);
    chk("t1_ready_setup",   32'(ready),       32'h0);
    req = 1'b0; d_wr_en = 1'b0; dAddr = 32'h1000_3000;
    tick();
    chk("t1_penable_access", 32'(apb.PENABLE), 32'h1);
    chk("t1_paddr_hold",     apb.PADDR,        32'h1000_1004);
    chk("t1_pwrite_hold",    32'(apb.PWRITE),  32'h1);
    chk("t1_ready_access",   32'(ready),       32'h0);
    tick();
    chk("t1_ready",        32'(ready),       32'h1);
    chk("t1_err",          32'(err),         32'h0);
    chk("t1_psel_done",    32'(apb.PSEL),    32'h0);
    chk("t1_penable_done", 32'(apb.PENABLE), 32'h0);
    tick();
    chk("t1_ready_pulse",  32'(ready),       32'h0);

    // Word load with five wait states.
    apb.PREADY = 1'b0;
    drive(1'b0, 32'h1000_2000, 32'h0, SZ_WORD);
    tick();
    chk("t2_psel",   32'(apb.PSEL),   32'h4);
    chk("t2_pstrb",  32'(apb.PSTRB),  32'h0);
    chk("t2_pwrite", 32'(apb.PWRITE), 32'h0);
    req = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_wait_ready",   32'(ready),       32'h0);
      chk("t2_wait_penable", 32'(apb.PENABLE), 32'h1);
      tick();
    end
    chk("t2_psel_hold", 32'(apb.PSEL), 32'h4);
    chk("t2_ready_pre", 32'(ready),    32'h0);
    apb.PREADY = 1'b1; apb.PRDATA = 32'hCAFE_F00D;
    tick();
    chk("t2_ready",  32'(ready), 32'h1);
    chk("t2_err",    32'(err),   32'h0);
    chk("t2_rdata",  dRdata,     32'hCAFE_F00D);

    // Half store with slave error, issued in the ready cycle of the load.
    apb.PRDATA = 32'h0;
    apb.PSLVERR = 1'b1;
    drive(1'b1, 32'h1000_3002, 32'h0000_1234, SZ_HALF);
    tick();
    chk("t3_psel",   32'(apb.PSEL),  32'h8);
    chk("t3_pstrb",  32'(apb.PSTRB), 32'hC);
    chk("t3_pwdata", apb.PWDATA,     32'h1234_1234);
    chk("t3_paddr",  apb.PADDR,      32'h1000_3000);
    req = 1'b0;
    tick(); tick();
    chk("t3_ready",      32'(ready), 32'h1);
    chk("t3_err",        32'(err),   32'h1);
    chk("t3_rdata_hold", dRdata,     32'hCAFE_F00D);

    // Byte store back-to-back with the half store.
    apb.PSLVERR = 1'b0;
    drive(1'b1, 32'h1000_0003, 32'h0000_00AB, SZ_BYTE);
    tick();
    chk("t4_pwdata", apb.PWDATA,     32'hABAB_ABAB);
    chk("t4_pstrb",  32'(apb.PSTRB), 32'h8);
    chk("t4_paddr",  apb.PADDR,      32'h1000_0000);
    chk("t4_psel",   32'(apb.PSEL),  32'h1);
    req = 1'b0;
    tick(); tick();
    chk("t4_ready",      32'(ready), 32'h1);
    chk("t4_err",        32'(err),   32'h0);
    chk("t4_rdata_hold", dRdata,     32'hCAFE_F00D);
    tick();
    chk("t4_ready_idle", 32'(ready), 32'h0);
    chk("t4_err_idle",   32'(err),   32'h0);

    // Misaligned half load: immediate error, no APB activity.
    drive(1'b0, 32'h1000_0001, 32'h0, SZ_HALF);
    tick();
    chk("t5_ready",   32'(ready),       32'h1);
    chk("t5_err",     32'(err),         32'h1);
    chk("t5_psel",    32'(apb.PSEL),    32'h0);
    chk("t5_penable", 32'(apb.PENABLE), 32'h0);
    chk("t5_rdata",   dRdata,           32'h0);
    req = 1'b0;
    tick();
    chk("t5_ready_pulse", 32'(ready), 32'h0);
    chk("t5_err_pulse",   32'(err),   32'h0);

    // Slave index 7 does not exist.
    drive(1'b1, 32'h1000_7000, 32'h1111_1111, SZ_WORD);
    tick();
    chk("t6_ready", 32'(ready),    32'h1);
    chk("t6_err",   32'(err),      32'h1);
    chk("t6_psel",  32'(apb.PSEL), 32'h0);
    req = 1'b0;
    tick();
    chk("t6_ready_pulse", 32'(ready), 32'h0);

    // Slave never answers: 16 ACCESS cycles then timeout.
    apb.PREADY = 1'b0;
    drive(1'b0, 32'h1000_0000, 32'h0, SZ_WORD);
    tick();
    req = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("t7_psel_last",    32'(apb.PSEL),    32'h1);
    chk("t7_penable_last", 32'(apb.PENABLE), 32'h1);
    chk("t7_ready_last",   32'(ready),       32'h0);
    tick();
    chk("t7_psel_drop",    32'(apb.PSEL),    32'h0);
    chk("t7_penable_drop", 32'(apb.PENABLE), 32'h0);
    chk("t7_ready",        32'(ready),       32'h1);
    chk("t7_err",          32'(err),         32'h1);
    chk("t7_rdata",        dRdata,           32'hDEAD_BEEF);
    tick();
    chk("t7_ready_pulse",  32'(ready), 32'h0);
    chk("t7_err_pulse",    32'(err),   32'h0);

    // Asynchronous reset during ACCESS, then a normal transfer.
    drive(1'b1, 32'h1000_1000, 32'h5555_AAAA, SZ_WORD);
    tick();
    req = 1'b0;
    tick();
    chk("t8_penable_pre", 32'(apb.PENABLE), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("t8_psel",    32'(apb.PSEL),    32'h0);
    chk("t8_penable", 32'(apb.PENABLE), 32'h0);
    chk("t8_paddr",   apb.PADDR,        32'h0);
    chk("t8_pwdata",  apb.PWDATA,       32'h0);
    chk("t8_pstrb",   32'(apb.PSTRB),   32'h0);
    chk("t8_pwrite",  32'(apb.PWRITE),  32'h0);
    chk("t8_rdata",   dRdata,           32'h0);
    tick(); tick();
    chk("t8_ready_in_rst", 32'(ready), 32'h0);
    rst = 1'b1;
    tick();
    chk("t8_ready_after", 32'(ready), 32'h0);
    apb.PREADY = 1'b1; apb.PRDATA = 32'h0BAD_F00D;
    drive(1'b0, 32'h1000_1008, 32'h0, SZ_WORD);
    tick();
    chk("t9_psel",  32'(apb.PSEL), 32'h2);
    chk("t9_paddr", apb.PADDR,     32'h1000_1008);
    req = 1'b0;
    tick(); tick();
    chk("t9_ready", 32'(ready), 32'h1);
    chk("t9_err",   32'(err),   32'h0);
    chk("t9_rdata", dRdata,     32'h0BAD_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
